// File: rtl/rgb_window_buffer_if.sv
// +----------------------------------------------------------------------------+
// | Module      : rgb_window_buffer_if                                          |
// | Description : Pixel stream in / RGB 3x3 window stream out bundle.           |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rgb_window_buffer_if;
  logic [23:0] pixel_in;
  logic        pixel_valid;
  logic        sof;
  logic [71:0] red_data;
  logic [71:0] green_data;
  logic [71:0] blue_data;
  logic        window_valid;

  modport master (
    output pixel_in, pixel_valid, sof,
    input  red_data, green_data, blue_data, window_valid
  );

  modport slave (
    input  pixel_in, pixel_valid, sof,
    output red_data, green_data, blue_data, window_valid
  );
endinterface

`default_nettype wire

// File: rtl/rgb_window_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : rgb_window_buffer                                             |
// | Description : Raster RGB stream to per-channel interior 3x3 windows.        |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module rgb_window_buffer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                clk,
  input  logic                n_rst,
  rgb_window_buffer_if.slave  bus
);

  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

  logic [c_COL_W-1:0] r_col, w_col, w_col_nxt;
  logic [c_ROW_W-1:0] r_row, w_row, w_row_nxt;
  logic [23:0]        r_lb0 [IMG_WIDTH];
  logic [23:0]        r_lb1 [IMG_WIDTH];
  logic [23:0]        w_tap0, w_tap1;
  logic [2:0][2:0][23:0] r_win;  // [column][row], column 0 / row 0 oldest
  logic               r_valid;
  logic [71:0]        w_red, w_green, w_blue;

  // sof forces the accepted pixel to (0,0) whatever the counters say
  always_comb begin
    w_col  = bus.sof ? '0 : r_col;
    w_row  = bus.sof ? '0 : r_row;
    w_tap0 = r_lb0[w_col];
    w_tap1 = r_lb1[w_col];
    if (w_col == c_COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == c_ROW_LAST) ? '0 : w_row + c_ROW_W'(1);
    end else begin
      w_col_nxt = w_col + c_COL_W'(1);
      w_row_nxt = w_row;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.pixel_valid) begin
      r_lb0[w_col] <= w_tap1;
      r_lb1[w_col] <= bus.pixel_in;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_valid <= 1'b0;
    end else if (bus.pixel_valid) begin
      r_col    <= w_col_nxt;
      r_row    <= w_row_nxt;
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= {bus.pixel_in, w_tap1, w_tap0};
      r_valid  <= (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_comb begin
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    for (int wr = 0; wr < 3; wr++) begin
      for (int wc = 0; wc < 3; wc++) begin
        w_red  [8*(3*wr+wc) +: 8] = r_win[wc][wr][23:16];
        w_green[8*(3*wr+wc) +: 8] = r_win[wc][wr][15:8];
        w_blue [8*(3*wr+wc) +: 8] = r_win[wc][wr][7:0];
      end
    end
  end

  assign bus.red_data     = w_red;
  assign bus.green_data   = w_green;
  assign bus.blue_data    = w_blue;
  assign bus.window_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rgb_window_buffer.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_rgb_window_buffer                                          |
// | Description : Randomised and directed bench against a frame-array model.    |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rgb_window_buffer;
  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rgb_window_buffer_if bus ();

  rgb_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic        exp_valid;
  logic [71:0] exp_r, exp_g, exp_b;
  bit          known;
  int          mr, mc;
  logic [23:0] img [H][W];

  task automatic chk72(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pv(input int r, input int c);
    int v;
    v = 4 * r + c;
    return {8'(v), 8'(128 + v), 8'(255 - v)};
  endfunction

  // Model: store each accepted pixel at its frame position; a window is the
  // 3x3 block of that frame ending at the pixel just accepted.
  task automatic model_accept(input logic [23:0] p, input logic s);
    logic [23:0] q;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = p;
    exp_valid = (mr >= 2) && (mc >= 2);
    if (exp_valid) begin
      for (int wr = 0; wr < 3; wr++) begin
        for (int wc = 0; wc < 3; wc++) begin
          q = img[mr-2+wr][mc-2+wc];
          exp_r[8*(3*wr+wc) +: 8] = q[23:16];
          exp_g[8*(3*wr+wc) +: 8] = q[15:8];
          exp_b[8*(3*wr+wc) +: 8] = q[7:0];
        end
      end
    end
    known = exp_valid;
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_r = '0;
    exp_g = '0;
    exp_b = '0;
    known = 1'b1;
    mr = 0;
    mc = 0;
  endtask

  always @(negedge clk) begin
    chk72("window_valid", {71'd0, bus.window_valid}, {71'd0, exp_valid});
    if (known) begin
      chk72("red_data", bus.red_data, exp_r);
      chk72("green_data", bus.green_data, exp_g);
      chk72("blue_data", bus.blue_data, exp_b);
    end
    if (bus.window_valid === 1'b1) pulses++;
  end

  task automatic drive(input logic v, input logic s, input logic [23:0] p);
    @(negedge clk);
    bus.pixel_valid = v;
    bus.sof         = s;
    bus.pixel_in    = p;
    @(posedge clk);
    if (v) model_accept(p, s);
    else   exp_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap, input bit first_sof, input bit pin);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, first_sof && r == 0 && c == 0, pv(r, c));
        if (pin && r == 2 && c == 2) begin
          #1;
          chk72("first_red", bus.red_data, 72'h0A0908060504020100);
          chk72("first_green_ctr", {64'd0, bus.green_data[39:32]}, 72'h85);
          chk72("first_blue_ctr", {64'd0, bus.blue_data[39:32]}, 72'hFA);
          chk72("model_pin_red", exp_r, 72'h0A0908060504020100);
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 24'($urandom));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    n_rst = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.sof = 1'b0;
    model_reset();
    #1;
    chk72("rst_valid", {71'd0, bus.window_valid}, 72'd0);
    chk72("rst_red", bus.red_data, 72'd0);
    chk72("rst_green", bus.green_data, 72'd0);
    chk72("rst_blue", bus.blue_data, 72'd0);
    repeat (2) drive(1'b0, 1'b0, 24'd0);
    @(negedge clk);
    #1;
    n_rst = 1'b1;
  endtask

  initial begin
    n_rst = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.sof = 1'b0;
    bus.pixel_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_rst = 1'b1;

    // Continuous frame with sof on the first pixel
    pulses = 0;
    send_frame(0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 24'd0);
    chk_int("pulses_continuous", pulses, 4);

    // Two idle cycles after every pixel
    pulses = 0;
    send_frame(2, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 24'd0);
    chk_int("pulses_gapped", pulses, 4);

    // Back-to-back frames, second without sof
    pulses = 0;
    send_frame(0, 1'b1, 1'b0);
    send_frame(0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 24'd0);
    chk_int("pulses_b2b", pulses, 8);

    // sof arrives where frame-1 pixel (3,0) would be
    pulses = 0;
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, pv(i / W, i % W));
    for (int i = 0; i < W * H; i++) drive(1'b1, i == 0, pv(i / W, i % W));
    drive(1'b0, 1'b0, 24'd0);
    chk_int("pulses_sof_abort", pulses, 6);

    // Reset after pixel (2,3), restart without sof
    pulses = 0;
    for (int i = 0; i < 12; i++) drive(1'b1, i == 0, pv(i / W, i % W));
    do_reset();
    send_frame(0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 24'd0);
    chk_int("pulses_after_reset", pulses, 6);

    // Quiet after reset
    pulses = 0;
    do_reset();
    repeat (20) drive(1'b0, 1'b0, 24'($urandom));
    chk_int("pulses_idle", pulses, 0);

    // Random traffic: gaps, occasional sof and reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(199) == 0) do_reset();
      else drive($urandom_range(9) < 7, $urandom_range(39) == 0, 24'($urandom));
    end
    drive(1'b0, 1'b0, 24'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/rgb_window_buffer.md
# rgb_window_buffer

Streaming 3x3 neighbourhood generator placed directly upstream of the noise/edge filter stage. Accepts one raster-order 24-bit RGB pixel per valid cycle, keeps the two previous image rows in line buffers, and emits per-channel 3x3 windows packed as 72-bit words. These 72-bit words feed the filter's red, green and blue window inputs. Only fully interior windows are emitted; there is no border padding.

## Interface
- IMG_WIDTH, 640, pixels per row; must be >= 3.
- IMG_HEIGHT, 480, rows per frame; must be >= 3.
- clk  input  1  system clock; all state is updated on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- pixel_in  input  24  {R[23:16], G[15:8], B[7:0]}.
- pixel_valid  input  1  pixel_in is accepted on any rising edge where this is 1.
- sof  input  1  start of frame; only meaningful when pixel_valid=1. It marks the accepted pixel as (row 0, col 0).
- red_data  output  72  red 3x3 window.
- green_data  output  72  green 3x3 window.
- blue_data  output  72  blue 3x3 window.
- window_valid  output  1  the windows are new this cycle.

## Operation
- Window packing: element k = 3*wr + wc occupies bits [8k+7:8k].
  - wr=0 is the oldest (top) row; wc=0 is the oldest (left) column.
  - [7:0] is top-left, [39:32] is the centre, [71:64] is bottom-right.
- Counters: col in 0..IMG_WIDTH-1 and row in 0..IMG_HEIGHT-1, each sized with $clog2.
  - Counters advance only on accepted pixels.
  - col wraps to 0 and increments row; row wraps from IMG_HEIGHT-1 to 0, so the next frame starts implicitly.
- sof handling: an accepted pixel with sof=1 is processed as (0,0), regardless of the current counters.
  - Counters then become col=1, row=0.
  - A frame aborted this way never emits its remaining windows.
- Line buffers: lb1 holds the previous row and lb0 the row before it, each IMG_WIDTH x 24 bits. On an accepted pixel p at (r,c):
  - read tap1=lb1[c] and tap0=lb0[c];
  - write lb0[c]<=tap1 and lb1[c]<=p.
- Window shift register: 3 columns x 3 rows x 24 bits.
  - On acceptance, column 0 <= column 1 and column 1 <= column 2.
  - Column 2 <= {row0: tap0, row1: tap1, row2: p}.
- Output assignment: red, green and blue data are the channel slices of the shift register, registered.
- window_valid: the next-cycle value is pixel_valid && r>=2 && c>=2, evaluated on the pixel just accepted.
  - The emitted window covers rows r-2..r and cols c-2..c, centred on (r-1,c-1).
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are emitted per complete frame.
- Stale data: windows at c<2 contain data from the previous row, and rows <2 contain data from the previous frame or reset. Both are masked by window_valid and are never flagged valid.
- No backpressure: the downstream stage consumes every valid window.
- Idle cycles (pixel_valid=0) freeze all state. Data outputs hold their last value and window_valid=0.

## Timing
- Reset values (n_rst=0, asynchronous):
  - red_data, green_data, blue_data = 0; window_valid = 0;
  - row = col = 0; shift register = 0.
  - Line buffer contents need not be cleared.
- Latency: window_valid and the data outputs update 1 cycle after the rising edge that accepts the completing pixel.
- Throughput: one pixel per cycle, so one window per cycle while streaming through interior columns.
- window_valid is a single-cycle pulse per window. It stays high across consecutive cycles during continuous interior streaming.
- Reset mid-frame: all outputs go to 0 immediately. The first pixel after reset is treated as (0,0), with or without sof.
- sof on the last pixel of a frame (row H-1, col W-1): the sof restart wins, no window is emitted for that pixel, and counters become col=1, row=0.

## Test plan
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4. Stimulus value v=4r+c gives R=v, G=0x80+v, B=0xFF-v.
- Continuous frame, sof on the first pixel: the first window_valid comes 1 cycle after pixel (2,2) (the 11th pixel).
  - red_data bytes k0..k8 = 0,1,2,4,5,6,8,9,10 ([7:0]=0x00, [71:64]=0x0A).
  - green_data [39:32] = 0x85; blue_data [39:32] = 0xFA.
  - Exactly 4 valid pulses, following pixels (2,2), (2,3), (3,2) and (3,3).
- Same frame with 2 idle cycles after every pixel: identical 4 windows in the same order.
  - Outputs hold between pulses; window_valid is never high on idle-following cycles.
- Two frames back-to-back, no sof on the second: the second frame yields 4 windows identical to the first, with red [7:0]=0 on its first window.
- sof asserted at frame-1 pixel (3,0): no pulse is emitted for frame-1 row 3. The new frame produces its first window after its own (2,2).
- n_rst pulsed low after pixel (2,3): all outputs read 0 during reset. The stream restarting at (0,0) produces correct windows from the new (2,2).
- After reset with no input: window_valid=0 and data outputs=0 indefinitely.
